// File: rtl/addr_manager_mq.sv
// Multi-queue buffer address manager: a shared free list and NUM_QUEUES linked
// queues threaded through one flop-based next-pointer table.
module addr_manager_mq #(
    parameter int ADDR_WIDTH            = 12,
    parameter int ADDR_TABLE_DEPTH      = 4096,
    parameter int NUM_QUEUES            = 4,
    parameter int QID_WIDTH             = 2,
    parameter int THRESHOLD_ALMOST_FULL = 48
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               s_axis_alloc_en,
    input  logic [QID_WIDTH-1:0]               s_axis_alloc_qid,
    input  logic                               s_axis_free_en,
    input  logic [QID_WIDTH-1:0]               s_axis_free_qid,
    output logic [ADDR_WIDTH-1:0]              m_axis_alloc_addr,
    output logic [ADDR_WIDTH-1:0]              m_axis_deq_addr,
    output logic [NUM_QUEUES*(ADDR_WIDTH+1)-1:0] m_axis_q_count,
    output logic [NUM_QUEUES-1:0]              m_axis_q_empty,
    output logic [ADDR_WIDTH:0]                m_axis_buffer_counter,
    output logic [ADDR_WIDTH:0]                m_axis_remain_space,
    output logic                               m_axis_almost_full,
    output logic                               m_axis_full,
    output logic                               m_axis_ready,
    output logic                               m_axis_err
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam int AF_LIMIT = ADDR_TABLE_DEPTH - THRESHOLD_ALMOST_FULL;
    localparam logic [CW-1:0] DEPTH_C = CW'(ADDR_TABLE_DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(ADDR_TABLE_DEPTH - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  ready_q, ready_d, err_q, err_d;
    logic [ADDR_WIDTH-1:0] free_head_q, free_head_d, free_tail_q, free_tail_d;
    logic [CW-1:0]         free_count_q, free_count_d;
    logic [ADDR_WIDTH-1:0] q_head_q [NUM_QUEUES];
    logic [ADDR_WIDTH-1:0] q_head_d [NUM_QUEUES];
    logic [ADDR_WIDTH-1:0] q_tail_q [NUM_QUEUES];
    logic [ADDR_WIDTH-1:0] q_tail_d [NUM_QUEUES];
    logic [CW-1:0]         q_count_q [NUM_QUEUES];
    logic [CW-1:0]         q_count_d [NUM_QUEUES];
    logic [ADDR_WIDTH-1:0] next_q [ADDR_TABLE_DEPTH];

    logic                  run, aqid_ok, fqid_ok, alloc_ok, free_ok;
    logic [QID_WIDTH-1:0]  aqid, fqid;
    logic [ADDR_WIDTH-1:0] alloc_addr, deq_addr;
    logic [NUM_QUEUES-1:0] push, pop;
    logic                  q_wr_en, f_wr_en;
    logic [ADDR_WIDTH-1:0] q_wr_idx, f_wr_idx;

    assign run        = (state_q == ST_RUN);
    assign aqid_ok    = int'(s_axis_alloc_qid) < NUM_QUEUES;
    assign fqid_ok    = int'(s_axis_free_qid) < NUM_QUEUES;
    assign aqid       = aqid_ok ? s_axis_alloc_qid : '0;
    assign fqid       = fqid_ok ? s_axis_free_qid : '0;
    assign alloc_addr = free_head_q;
    assign deq_addr   = q_head_q[fqid];
    // Legality is decided purely on the registered state at the start of the cycle.
    assign alloc_ok   = run && s_axis_alloc_en && aqid_ok && (free_count_q != '0);
    assign free_ok    = run && s_axis_free_en && fqid_ok && (q_count_q[fqid] != '0);

    always_comb begin
        for (int q = 0; q < NUM_QUEUES; q++) begin
            push[q] = alloc_ok && (int'(aqid) == q);
            pop[q]  = free_ok && (int'(fqid) == q);
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        ready_d      = ready_q;
        err_d        = err_q;
        free_head_d  = free_head_q;
        free_tail_d  = free_tail_q;
        free_count_d = free_count_q;
        q_head_d     = q_head_q;
        q_tail_d     = q_tail_q;
        q_count_d    = q_count_q;
        q_wr_en      = 1'b0;
        q_wr_idx     = '0;
        f_wr_en      = 1'b0;
        f_wr_idx     = '0;

        case (state_q)
            ST_INIT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: ;
        endcase

        if ((s_axis_alloc_en && !alloc_ok) || (s_axis_free_en && !free_ok))
            err_d = 1'b1;

        if (alloc_ok)
            free_head_d = next_q[alloc_addr];
        // A freed cell re-seeds the head when the list is, or is about to become, empty.
        if (free_ok) begin
            if ((free_count_q == '0) || (alloc_ok && (free_count_q == CNT_ONE))) begin
                free_head_d = deq_addr;
            end else begin
                f_wr_en  = 1'b1;
                f_wr_idx = free_tail_q;
            end
            free_tail_d = deq_addr;
        end
        if (alloc_ok && !free_ok)
            free_count_d = free_count_q - 1'b1;
        else if (free_ok && !alloc_ok)
            free_count_d = free_count_q + 1'b1;

        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (pop[q])
                q_head_d[q] = next_q[q_head_q[q]];
            if (push[q]) begin
                if ((q_count_q[q] == '0) || (pop[q] && (q_count_q[q] == CNT_ONE))) begin
                    q_head_d[q] = alloc_addr;
                end else begin
                    q_wr_en  = 1'b1;
                    q_wr_idx = q_tail_q[q];
                end
                q_tail_d[q] = alloc_addr;
            end
            if (push[q] && !pop[q])
                q_count_d[q] = q_count_q[q] + 1'b1;
            else if (pop[q] && !push[q])
                q_count_d[q] = q_count_q[q] - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_INIT;
            idx_q        <= '0;
            ready_q      <= 1'b0;
            err_q        <= 1'b0;
            free_head_q  <= '0;
            free_tail_q  <= LAST_IDX;
            free_count_q <= DEPTH_C;
            for (int q = 0; q < NUM_QUEUES; q++) begin
                q_head_q[q]  <= '0;
                q_tail_q[q]  <= '0;
                q_count_q[q] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            ready_q      <= ready_d;
            err_q        <= err_d;
            free_head_q  <= free_head_d;
            free_tail_q  <= free_tail_d;
            free_count_q <= free_count_d;
            q_head_q     <= q_head_d;
            q_tail_q     <= q_tail_d;
            q_count_q    <= q_count_d;
        end
    end

    // The pointer table needs no reset: INIT rewrites every entry before use.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT)
            next_q[idx_q] <= idx_q + 1'b1;
        if (q_wr_en)
            next_q[q_wr_idx] <= alloc_addr;
        if (f_wr_en)
            next_q[f_wr_idx] <= deq_addr;
    end

    always_comb begin
        for (int q = 0; q < NUM_QUEUES; q++) begin
            m_axis_q_count[q*CW +: CW] = q_count_q[q];
            m_axis_q_empty[q]          = (q_count_q[q] == '0);
        end
    end

    assign m_axis_alloc_addr     = alloc_addr;
    assign m_axis_deq_addr       = deq_addr;
    assign m_axis_remain_space   = free_count_q;
    assign m_axis_buffer_counter = DEPTH_C - free_count_q;
    assign m_axis_almost_full    = (AF_LIMIT < 0) || (int'(m_axis_buffer_counter) > AF_LIMIT);
    assign m_axis_full           = (free_count_q == '0);
    assign m_axis_ready          = ready_q;
    assign m_axis_err            = err_q;
endmodule

// File: tb/tb_addr_manager_mq.sv
// Bench for addr_manager_mq: directed scenarios plus random traffic, checked
// against a queue-based model of the free list and the per-queue FIFOs.
module tb_addr_manager_mq;
    localparam int AW = 3, DEPTH = 8, NQ = 2, QW = 1, TH = 3, CW = AW + 1;

    logic clk = 1'b0;
    logic rstn;
    logic ae, fe;
    logic [QW-1:0] aq, fq;
    logic [AW-1:0] alloc_addr, deq_addr;
    logic [NQ*CW-1:0] q_count;
    logic [NQ-1:0] q_empty;
    logic [AW:0] buf_cnt, remain;
    logic afull, full, ready, err;

    always #5 clk = ~clk;

    addr_manager_mq #(
        .ADDR_WIDTH(AW), .ADDR_TABLE_DEPTH(DEPTH), .NUM_QUEUES(NQ),
        .QID_WIDTH(QW), .THRESHOLD_ALMOST_FULL(TH)
    ) dut (
        .clk(clk), .rstn(rstn),
        .s_axis_alloc_en(ae), .s_axis_alloc_qid(aq),
        .s_axis_free_en(fe), .s_axis_free_qid(fq),
        .m_axis_alloc_addr(alloc_addr), .m_axis_deq_addr(deq_addr),
        .m_axis_q_count(q_count), .m_axis_q_empty(q_empty),
        .m_axis_buffer_counter(buf_cnt), .m_axis_remain_space(remain),
        .m_axis_almost_full(afull), .m_axis_full(full),
        .m_axis_ready(ready), .m_axis_err(err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int freeq[$];
    int qq[NQ][$];
    bit m_err, m_ready;
    int m_init;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        freeq.delete();
        for (int i = 0; i < DEPTH; i++) freeq.push_back(i);
        for (int q = 0; q < NQ; q++) qq[q].delete();
        m_err = 1'b0;
        m_ready = 1'b0;
        m_init = 0;
    endtask

    task automatic model_update(input bit a_en, input int a_q, input bit f_en, input int f_q);
        bit al, fr;
        int a, d;
        a = 0;
        d = 0;
        if (!m_ready) begin
            if (a_en || f_en) m_err = 1'b1;
            m_init++;
            if (m_init == DEPTH) m_ready = 1'b1;
            return;
        end
        al = a_en && (freeq.size() > 0);
        fr = f_en && (qq[f_q].size() > 0);
        if ((a_en && !al) || (f_en && !fr)) m_err = 1'b1;
        if (al) a = freeq[0];
        if (fr) d = qq[f_q][0];
        if (fr) void'(qq[f_q].pop_front());
        if (al) begin
            void'(freeq.pop_front());
            qq[a_q].push_back(a);
        end
        if (fr) freeq.push_back(d);
    endtask

    task automatic compare();
        int fqi, used;
        fqi  = int'(fq);
        used = DEPTH - freeq.size();
        check_eq("ready", ready, m_ready);
        check_eq("err", err, m_err);
        check_eq("remain_space", remain, freeq.size());
        check_eq("buffer_counter", buf_cnt, used);
        check_eq("full", full, freeq.size() == 0);
        check_eq("almost_full", afull, used > DEPTH - TH);
        if (freeq.size() > 0) check_eq("alloc_addr", alloc_addr, freeq[0]);
        for (int q = 0; q < NQ; q++) begin
            check_eq("q_count", q_count[q*CW +: CW], qq[q].size());
            check_eq("q_empty", q_empty[q], qq[q].size() == 0);
        end
        if (qq[fqi].size() > 0) check_eq("deq_addr", deq_addr, qq[fqi][0]);
    endtask

    // One clock: drive at the falling edge, check just after, advance the model on the rising edge.
    task automatic step(input bit a_en, input int a_q, input bit f_en, input int f_q,
                        output int got_alloc, output int got_deq);
        @(negedge clk);
        ae = a_en;
        aq = QW'(a_q);
        fe = f_en;
        fq = QW'(f_q);
        #1;
        compare();
        got_alloc = int'(alloc_addr);
        got_deq   = int'(deq_addr);
        @(posedge clk);
        model_update(a_en, a_q, f_en, f_q);
    endtask

    task automatic idle(input int n);
        int ga, gd;
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0, ga, gd);
    endtask

    // Called right after a rising edge: asserts reset between edges and checks it bites at once.
    task automatic do_reset();
        #2 rstn = 1'b0;
        #1;
        model_reset();
        check_eq("rst_ready", ready, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_remain", remain, DEPTH);
        check_eq("rst_bufcnt", buf_cnt, 0);
        check_eq("rst_alloc_addr", alloc_addr, 0);
        check_eq("rst_q_empty", q_empty, {NQ{1'b1}});
        compare();
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
    endtask

    task automatic fresh();
        do_reset();
        idle(DEPTH);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ga, gd, a_q, f_q;
        bit a_en, f_en;
        rstn = 1'b0;
        ae = 1'b0; aq = '0; fe = 1'b0; fq = '0;
        @(posedge clk);

        // Init: ready low for DEPTH edges, then high
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 0, 1'b0, 0, ga, gd);
            check_eq("init_ready_low", m_ready, i == DEPTH - 1);
        end
        step(1'b0, 0, 1'b0, 0, ga, gd);
        check_eq("init_ready_high", ready, 1);
        check_eq("init_alloc_addr", ga, 0);

        // FIFO order on queue 0
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 0, 1'b0, 0, ga, gd);
            check_eq("fifo_alloc", ga, i);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 0, 1'b1, 0, ga, gd);
            check_eq("fifo_deq", gd, i);
        end
        step(1'b0, 0, 1'b0, 0, ga, gd);
        check_eq("fifo_empty0", q_empty[0], 1);
        check_eq("fifo_bufcnt", buf_cnt, 0);

        // Interleaved queues
        fresh();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, i % 2, 1'b0, 0, ga, gd);
            check_eq("ilv_alloc", ga, i);
        end
        step(1'b0, 0, 1'b1, 1, ga, gd);
        check_eq("ilv_deq_q1", gd, 1);
        step(1'b0, 0, 1'b1, 0, ga, gd);
        check_eq("ilv_deq_q0", gd, 0);
        step(1'b0, 0, 1'b0, 0, ga, gd);
        check_eq("ilv_count", q_count, {CW'(1), CW'(1)});

        // Simultaneous alloc+free with one free cell left
        fresh();
        for (int i = 0; i < 7; i++) step(1'b1, (i < 4) ? 0 : 1, 1'b0, 0, ga, gd);
        step(1'b1, 1, 1'b1, 0, ga, gd);
        check_eq("sim_alloc", ga, 7);
        check_eq("sim_deq", gd, 0);
        step(1'b1, 0, 1'b0, 0, ga, gd);
        check_eq("sim_realloc", ga, 0);
        step(1'b0, 0, 1'b0, 0, ga, gd);
        check_eq("sim_remain", remain, 0);
        // Same queue, single occupant, popped and pushed together
        fresh();
        step(1'b1, 1, 1'b0, 0, ga, gd);
        step(1'b1, 1, 1'b1, 1, ga, gd);
        check_eq("sameq_alloc", ga, 1);
        check_eq("sameq_deq", gd, 0);
        step(1'b0, 0, 1'b1, 1, ga, gd);
        check_eq("sameq_head", gd, 1);

        // Full, overflow and underflow errors
        fresh();
        for (int i = 0; i < DEPTH; i++) step(1'b1, i % 2, 1'b0, 0, ga, gd);
        step(1'b1, 0, 1'b0, 0, ga, gd);
        check_eq("full_flag", full, 1);
        check_eq("full_afull", afull, 1);
        check_eq("full_err_before", err, 0);
        step(1'b0, 0, 1'b0, 0, ga, gd);
        check_eq("overflow_err", err, 1);
        for (int i = 0; i < DEPTH / 2; i++) step(1'b0, 0, 1'b1, 1, ga, gd);
        step(1'b0, 0, 1'b1, 1, ga, gd);
        step(1'b0, 0, 1'b0, 0, ga, gd);
        check_eq("underflow_err", err, 1);
        check_eq("underflow_remain", remain, DEPTH / 2);

        // Reset mid-traffic
        fresh();
        for (int i = 0; i < 5; i++) step(1'b1, i % 2, 1'b0, 0, ga, gd);
        do_reset();
        idle(DEPTH);
        step(1'b0, 0, 1'b0, 0, ga, gd);
        check_eq("rerun_ready", ready, 1);

        // Random legal-only traffic: err must stay clear
        for (int i = 0; i < 400; i++) begin
            a_q  = $urandom_range(0, NQ - 1);
            f_q  = $urandom_range(0, NQ - 1);
            a_en = ($urandom_range(0, 99) < 55) && (freeq.size() > 0);
            f_en = ($urandom_range(0, 99) < 45) && (qq[f_q].size() > 0);
            step(a_en, a_q, f_en, f_q, ga, gd);
        end

        // Random unrestricted traffic
        fresh();
        for (int i = 0; i < 400; i++) begin
            a_q  = $urandom_range(0, NQ - 1);
            f_q  = $urandom_range(0, NQ - 1);
            a_en = $urandom_range(0, 1);
            f_en = $urandom_range(0, 1);
            step(a_en, a_q, f_en, f_q, ga, gd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/addr_manager_mq.md
# addr_manager_mq

Multi-queue buffer address manager: one shared free list plus NUM_QUEUES per-queue linked lists, all threaded through a single next-pointer table held in flip-flops. A write path allocates a buffer address and appends it to a queue. A read path pops the head of a queue and returns that address to the free list. It sits between the packet buffer RAM and the PIFO/scheduler, replacing the single-queue address manager, and also carries per-queue occupancy statistics.

## Interface
- ADDR_WIDTH, 12, address bit width.
- ADDR_TABLE_DEPTH, 4096, number of buffer cells; 2 ≤ value ≤ 2^ADDR_WIDTH.
- NUM_QUEUES, 4, number of linked queues.
- QID_WIDTH, 2, queue-id width; 2^QID_WIDTH ≥ NUM_QUEUES.
- THRESHOLD_ALMOST_FULL, 48, almost-full margin in cells.

Ports:
- clk  in  1  single clock, rising edge.
- rstn  in  1  reset, asynchronous assert, active-low.
- s_axis_alloc_en  in  1  allocate one cell and append it to queue s_axis_alloc_qid.
- s_axis_alloc_qid  in  QID_WIDTH  target queue for alloc.
- s_axis_free_en  in  1  pop the head of queue s_axis_free_qid and free it.
- s_axis_free_qid  in  QID_WIDTH  source queue for free.
- m_axis_alloc_addr  out  ADDR_WIDTH  current free-list head; the address granted by alloc this cycle.
- m_axis_deq_addr  out  ADDR_WIDTH  head of queue s_axis_free_qid (combinational).
- m_axis_q_count  out  NUM_QUEUES*(ADDR_WIDTH+1)  per-queue cell counts, queue 0 in the LSBs.
- m_axis_q_empty  out  NUM_QUEUES  per-queue empty flags.
- m_axis_buffer_counter  out  ADDR_WIDTH+1  total cells in use.
- m_axis_remain_space  out  ADDR_WIDTH+1  free cells.
- m_axis_almost_full  out  1  buffer_counter > ADDR_TABLE_DEPTH − THRESHOLD_ALMOST_FULL.
- m_axis_full  out  1  remain_space == 0.
- m_axis_ready  out  1  initialisation complete.
- m_axis_err  out  1  sticky flag for an illegal request.

## Operation
- State machine has two states, INIT and RUN. Reset forces INIT.
- **INIT:** index counter i walks 0..DEPTH−1, one entry per cycle, writing next[i] = i+1 (the value at DEPTH−1 is don't-care). After i = DEPTH−1 the block moves to RUN.
- **Register reset values:**
  - free_head = 0, free_tail = DEPTH−1, free_count = DEPTH.
  - All q_head, q_tail and q_count = 0.
  - err = 0, ready = 0.
- **Alloc is legal when** RUN and free_count > 0. Effect, with a = free_head:
  - free_head ← next[a].
  - If q_count[qid] == 0 then q_head ← a, else next[q_tail] ← a.
  - q_tail ← a; q_count++.
- **Free is legal when** RUN and q_count[qid] > 0. Effect, with d = q_head[qid]:
  - q_head ← next[d]; q_count−−.
  - If free_count == 0 then free_head ← d, else next[free_tail] ← d.
  - free_tail ← d.
- **Legality is judged on pre-cycle state.** An illegal request is ignored, sets err, and err holds until reset. Any request during INIT is illegal.
- **Simultaneous alloc and free (both legal):**
  - free_count == 1: the cell being allocated is free_tail, so free_head ← d and free_tail ← d; free_count is unchanged.
  - Same queue with q_count == 1: the popped cell is q_tail, so q_head ← a and q_tail ← a; q_count is unchanged.
  - The two next-table writes in one cycle always target distinct indices (one is a used cell, one is a free cell).
- **Counter arithmetic:** counters are ADDR_WIDTH+1 bits and never wrap. buffer_counter = DEPTH − free_count.

## Timing
- All state updates on the rising clk edge. Reset assertion takes effect immediately, without a clock.
- m_axis_alloc_addr and m_axis_deq_addr are combinational from registers and qid: the granted address is valid in the same cycle as the enable.
- After rstn deasserts, ready rises exactly DEPTH rising edges later.
- A queue popped in cycle N presents its new head in cycle N+1. An alloc in cycle N is visible through free in cycle N+1.
- Reset asserted mid-operation discards all lists, returns to INIT and repeats initialisation.

## Test plan
Benches use DEPTH=8, ADDR_WIDTH=3, NUM_QUEUES=2.
- **Init:** release rstn → ready=0 for 8 edges then 1; remain_space=8, alloc_addr=0, err=0.
- **FIFO order:** alloc q0 ×3 → addresses 0,1,2; free q0 ×3 → deq_addr 0,1,2; then q_empty[0]=1, buffer_counter=0.
- **Interleave:** alloc q0, q1, q0, q1 → q0 holds {0,2}, q1 holds {1,3}; free q1 → deq 1; free q0 → deq 0; q_count = {1,1}.
- **Simultaneous at boundary:** fill 7 cells (free_count=1); alloc q1 + free q0 together → alloc_addr=7, freed cell becomes both free_head and free_tail; next alloc returns the freed cell; counts are consistent.
- **Full and error:** alloc ×8 → full=1, almost_full asserted per threshold; 9th alloc → ignored, err=1; free on an empty queue → err stays 1, state unchanged.
- **Reset mid-traffic:** assert rstn low asynchronously between edges with 5 cells in use → all outputs at reset values immediately; ready returns 8 edges after release.
